// File: rtl/spi_sniff_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : spi_sniff_pkg
//  Description : Shared types and helpers for the passive SPI bus sniffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_sniff_pkg;

  // Capture FSM states. ARM waits for an idle (high) CS so that a frame
  // interrupted by reset is never captured half-way.
  typedef enum logic [1:0] {
    ST_ARM    = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  // Modes 0 and 3 sample on the rising SCK edge; modes 1 and 2 on the falling edge.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return (cpol == cpha);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sniff_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sniff_fifo
//  Description : Synchronous show-ahead FIFO. Head entry is always presented
//                on o_pop_data; a push while full is accepted only when a pop
//                frees the slot in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module sniff_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [WIDTH-1:0]   mem_d [DEPTH];
  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_cnt_w-1:0] count_q, count_d;
  logic               w_wr;
  logic               w_rd;

  assign o_full     = (count_q == c_depth);
  assign o_empty    = (count_q == '0);
  assign o_pop_data = mem_q[rd_ptr_q];
  assign w_rd       = i_pop & ~o_empty;
  assign w_wr       = i_push & (~o_full | w_rd);

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_wr) begin
      mem_d[wr_ptr_q] = i_push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (w_rd) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({w_wr, w_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; storage is cleared so outputs read zero out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_sniffer_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : spi_sniffer_rx
//  Description : Passive SPI monitor capturing MOSI and MISO words in any SPI
//                mode, MSB- or LSB-first, flagging partial words and
//                buffering them in a show-ahead output FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_sniffer_rx #(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_cpol,
  input  logic                        cfg_cpha,
  input  logic                        cfg_msb_first,
  input  logic                        spi_sck,
  input  logic                        spi_cs,
  input  logic                        spi_mosi,
  input  logic                        spi_miso,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_mosi,
  output logic [DATA_W-1:0]           out_miso,
  output logic [$clog2(DATA_W+1)-1:0] out_bits,
  output logic                        out_partial,
  output logic                        out_sof,
  output logic                        overflow,
  input  logic                        clear_ovf,
  output logic                        busy
);
  import spi_sniff_pkg::*;

  localparam int c_cnt_w = $clog2(DATA_W+1);
  localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(DATA_W);

  typedef struct packed {
    logic [DATA_W-1:0]  mosi;
    logic [DATA_W-1:0]  miso;
    logic [c_cnt_w-1:0] bits;
    logic               partial;
    logic               sof;
  } word_t;

  localparam int c_word_w = $bits(word_t);

  // Tap vector layout: {sck, cs, mosi, miso}
  logic [3:0]         sync_q [SYNC_STAGES];
  logic [3:0]         sync_d [SYNC_STAGES];
  logic [3:0]         prev_q, prev_d;
  state_e             state_q, state_d;
  logic               cpol_q, cpol_d;
  logic               cpha_q, cpha_d;
  logic               msb_q, msb_d;
  logic [c_cnt_w-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]  mosi_sr_q, mosi_sr_d;
  logic [DATA_W-1:0]  miso_sr_q, miso_sr_d;
  logic               sof_q, sof_d;
  logic               push_q, push_d;
  word_t              push_word_q, push_word_d;
  logic               overflow_q, overflow_d;

  logic               w_sck_s, w_cs_s, w_mosi_s, w_miso_s;
  logic               w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;
  logic               w_sample;
  logic [DATA_W-1:0]  w_mosi_nx, w_miso_nx;
  logic [c_cnt_w-1:0] w_cnt_nx;
  word_t              w_head;
  logic               w_full, w_empty;

  assign {w_sck_s, w_cs_s, w_mosi_s, w_miso_s} = sync_q[SYNC_STAGES-1];
  assign w_sck_rise = ~prev_q[3] &  w_sck_s;
  assign w_sck_fall =  prev_q[3] & ~w_sck_s;
  assign w_cs_rise  = ~prev_q[2] &  w_cs_s;
  assign w_cs_fall  =  prev_q[2] & ~w_cs_s;
  assign w_sample   = sample_on_rise(cpol_q, cpha_q) ? w_sck_rise : w_sck_fall;

  // Synchroniser shift chain plus one delayed copy for edge detection.
  always_comb begin
    sync_d[0] = {spi_sck, spi_cs, spi_mosi, spi_miso};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Frame FSM: ARM discards any frame already in flight at reset release.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARM:    if (w_cs_s)    state_d = ST_IDLE;
      ST_IDLE:   if (w_cs_fall) state_d = ST_ACTIVE;
      ST_ACTIVE: if (w_cs_rise) state_d = ST_IDLE;
      default:                  state_d = ST_ARM;
    endcase
  end

  // Shift/count datapath; a sample coincident with CS rise is taken first.
  always_comb begin
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    msb_d       = msb_q;
    bit_cnt_d   = bit_cnt_q;
    mosi_sr_d   = mosi_sr_q;
    miso_sr_d   = miso_sr_q;
    sof_d       = sof_q;
    push_d      = 1'b0;
    push_word_d = push_word_q;
    w_mosi_nx   = mosi_sr_q;
    w_miso_nx   = miso_sr_q;
    w_cnt_nx    = bit_cnt_q;
    if (state_q == ST_IDLE && w_cs_fall) begin
      cpol_d    = cfg_cpol;
      cpha_d    = cfg_cpha;
      msb_d     = cfg_msb_first;
      bit_cnt_d = '0;
      mosi_sr_d = '0;
      miso_sr_d = '0;
      sof_d     = 1'b1;
    end else if (state_q == ST_ACTIVE) begin
      if (w_sample) begin
        if (msb_q) begin
          w_mosi_nx = {mosi_sr_q[DATA_W-2:0], w_mosi_s};
          w_miso_nx = {miso_sr_q[DATA_W-2:0], w_miso_s};
        end else begin
          for (int i = 0; i < DATA_W; i++) begin
            if (bit_cnt_q == c_cnt_w'(i)) begin
              w_mosi_nx[i] = w_mosi_s;
              w_miso_nx[i] = w_miso_s;
            end
          end
        end
        w_cnt_nx = bit_cnt_q + 1'b1;
      end
      if (w_cnt_nx == c_full_cnt || (w_cs_rise && w_cnt_nx != '0)) begin
        push_d              = 1'b1;
        push_word_d.mosi    = w_mosi_nx;
        push_word_d.miso    = w_miso_nx;
        push_word_d.bits    = w_cnt_nx;
        push_word_d.partial = (w_cnt_nx != c_full_cnt);
        push_word_d.sof     = sof_q;
        bit_cnt_d           = '0;
        mosi_sr_d           = '0;
        miso_sr_d           = '0;
        sof_d               = 1'b0;
      end else begin
        bit_cnt_d = w_cnt_nx;
        mosi_sr_d = w_mosi_nx;
        miso_sr_d = w_miso_nx;
      end
    end
  end

  // Sticky overflow: a drop in the same cycle as clear_ovf keeps it set.
  always_comb begin
    overflow_d = (overflow_q & ~clear_ovf) | (push_q & w_full & ~out_ready);
  end

  // All state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q      <= '0;
      state_q     <= ST_ARM;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      msb_q       <= 1'b0;
      bit_cnt_q   <= '0;
      mosi_sr_q   <= '0;
      miso_sr_q   <= '0;
      sof_q       <= 1'b0;
      push_q      <= 1'b0;
      push_word_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      state_q     <= state_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      msb_q       <= msb_d;
      bit_cnt_q   <= bit_cnt_d;
      mosi_sr_q   <= mosi_sr_d;
      miso_sr_q   <= miso_sr_d;
      sof_q       <= sof_d;
      push_q      <= push_d;
      push_word_q <= push_word_d;
      overflow_q  <= overflow_d;
    end
  end

  sniff_fifo #(
    .WIDTH (c_word_w),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (push_q),
    .i_push_data (push_word_q),
    .i_pop       (out_ready),
    .o_pop_data  (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  assign out_valid   = ~w_empty;
  assign out_mosi    = w_head.mosi;
  assign out_miso    = w_head.miso;
  assign out_bits    = w_head.bits;
  assign out_partial = w_head.partial;
  assign out_sof     = w_head.sof;
  assign overflow    = overflow_q;
  assign busy        = (state_q == ST_ACTIVE);

endmodule
`default_nettype wire

// File: tb/tb_spi_sniffer_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_spi_sniffer_rx
//  Description : Scoreboard bench for spi_sniffer_rx. Frames are driven as
//                bit streams; expected words are decoded from those streams
//                and queued, and a monitor compares each accepted word.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_sniffer_rx;

  localparam int DATA_W      = 8;
  localparam int FIFO_DEPTH  = 4;
  localparam int SYNC_STAGES = 2;
  localparam int BITS_W      = $clog2(DATA_W+1);
  localparam int T_HALF      = 40;

  typedef struct packed {
    logic [DATA_W-1:0] mosi;
    logic [DATA_W-1:0] miso;
    logic [BITS_W-1:0] bits;
    logic              partial;
    logic              sof;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cfg_cpol = 1'b0, cfg_cpha = 1'b0, cfg_msb_first = 1'b1;
  logic              spi_sck = 1'b0, spi_cs = 1'b1, spi_mosi = 1'b0, spi_miso = 1'b0;
  logic              out_ready = 1'b0;
  logic              clear_ovf = 1'b0;
  logic              out_valid, out_partial, out_sof, overflow, busy;
  logic [DATA_W-1:0] out_mosi, out_miso;
  logic [BITS_W-1:0] out_bits;

  exp_t exp_q[$];
  exp_t exp_w, got_w;
  int   checks = 0;
  int   errors = 0;
  bit   hold_ready = 1'b0;

  spi_sniffer_rx #(
    .DATA_W      (DATA_W),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_cpol      (cfg_cpol),
    .cfg_cpha      (cfg_cpha),
    .cfg_msb_first (cfg_msb_first),
    .spi_sck       (spi_sck),
    .spi_cs        (spi_cs),
    .spi_mosi      (spi_mosi),
    .spi_miso      (spi_miso),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_mosi      (out_mosi),
    .out_miso      (out_miso),
    .out_bits      (out_bits),
    .out_partial   (out_partial),
    .out_sof       (out_sof),
    .overflow      (overflow),
    .clear_ovf     (clear_ovf),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Monitor: pick ready for the next edge, then score any word that edge accepts.
  always @(negedge clk) begin
    out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    if (rst && out_valid && out_ready) begin
      checks++;
      got_w = {out_mosi, out_miso, out_bits, out_partial, out_sof};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got mosi=%h miso=%h bits=%0d partial=%b sof=%b, none expected",
                 out_mosi, out_miso, out_bits, out_partial, out_sof);
      end else begin
        exp_w = exp_q.pop_front();
        if (got_w !== exp_w) begin
          errors++;
          $display("FAIL word: got mosi=%h miso=%h bits=%0d partial=%b sof=%b, expected mosi=%h miso=%h bits=%0d partial=%b sof=%b",
                   got_w.mosi, got_w.miso, got_w.bits, got_w.partial, got_w.sof,
                   exp_w.mosi, exp_w.miso, exp_w.bits, exp_w.partial, exp_w.sof);
        end
      end
    end
  end

  // Turn a list of words into a transmission-order bit stream.
  function automatic logic [63:0] words_to_bits(input logic [63:0] words, input int nwords, input bit msb);
    logic [63:0] r = '0;
    for (int i = 0; i < nwords; i++) begin
      for (int b = 0; b < DATA_W; b++) begin
        r[i*DATA_W + b] = words[i*DATA_W + (msb ? (DATA_W-1-b) : b)];
      end
    end
    return r;
  endfunction

  task automatic check1(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Expected words: every DATA_W bits form a word; a shorter tail is partial.
  task automatic model_frame(input bit msb, input int nbits, input logic [63:0] mb,
                             input logic [63:0] sb, input int max_store);
    int   stored = 0;
    int   n, pm, ps;
    exp_t e;
    for (int s = 0; s < nbits; s += DATA_W) begin
      n  = (nbits - s < DATA_W) ? (nbits - s) : DATA_W;
      pm = 0;
      ps = 0;
      for (int j = 0; j < n; j++) begin
        pm += int'(mb[s+j]) * (2 ** (msb ? (n-1-j) : j));
        ps += int'(sb[s+j]) * (2 ** (msb ? (n-1-j) : j));
      end
      e.mosi    = pm[DATA_W-1:0];
      e.miso    = ps[DATA_W-1:0];
      e.bits    = BITS_W'(n);
      e.partial = (n < DATA_W);
      e.sof     = (s == 0);
      if (stored < max_store) begin
        exp_q.push_back(e);
        stored++;
      end
    end
  endtask

  // Drive one CS frame; rst_at >= 0 pulses reset before that bit.
  task automatic run_frame(input bit cpol, input bit cpha, input bit msb, input int nbits,
                           input logic [63:0] mb, input logic [63:0] sb,
                           input int max_store, input bit toggle_cfg, input int rst_at);
    if (rst_at < 0) model_frame(msb, nbits, mb, sb, max_store);
    cfg_cpol      = cpol;
    cfg_cpha      = cpha;
    cfg_msb_first = msb;
    spi_sck       = cpol;
    #(T_HALF);
    spi_cs = 1'b0;
    #(T_HALF);
    if (toggle_cfg) begin
      cfg_cpol      = ~cpol;
      cfg_cpha      = ~cpha;
      cfg_msb_first = ~msb;
    end
    for (int k = 0; k < nbits; k++) begin
      if (k == rst_at) begin
        rst = 1'b0;
        #30;
        rst = 1'b1;
        #(T_HALF);
        check1("busy_after_midframe_reset", {31'd0, busy}, 32'd0);
        check1("valid_after_midframe_reset", {31'd0, out_valid}, 32'd0);
      end
      if (k == 1 && rst_at < 0) check1("busy_in_frame", {31'd0, busy}, 32'd1);
      if (!cpha) begin
        spi_mosi = mb[k];
        spi_miso = sb[k];
        #(T_HALF);
        spi_sck = ~cpol;
        #(T_HALF);
        spi_sck = cpol;
      end else begin
        spi_sck  = ~cpol;
        spi_mosi = mb[k];
        spi_miso = sb[k];
        #(T_HALF);
        spi_sck = cpol;
        #(T_HALF);
      end
    end
    #(T_HALF);
    spi_cs = 1'b1;
    #(2*T_HALF);
    cfg_cpol      = cpol;
    cfg_cpha      = cpha;
    cfg_msb_first = msb;
  endtask

  task automatic wait_drain();
    int cyc = 0;
    while ((exp_q.size() != 0 || out_valid) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (exp_q.size() != 0 || out_valid) begin
      errors++;
      $display("FAIL drain: %0d expected words still pending, out_valid=%b after %0d cycles",
               exp_q.size(), out_valid, cyc);
    end
  endtask

  logic [63:0] mb, sb;

  initial begin
    #22;
    check1("reset_outputs",
           {out_valid, out_partial, out_sof, overflow, busy, out_bits, out_mosi, out_miso},
           32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Mode 0, MSB-first, A5/3C
    mb = words_to_bits(64'hA5, 1, 1'b1);
    sb = words_to_bits(64'h3C, 1, 1'b1);
    run_frame(1'b0, 1'b0, 1'b1, 8, mb, sb, 99, 1'b0, -1);
    wait_drain();

    // Mode 3, two words in one frame
    mb = words_to_bits(64'h3412, 2, 1'b1);
    sb = words_to_bits(64'hC3E7, 2, 1'b1);
    run_frame(1'b1, 1'b1, 1'b1, 16, mb, sb, 99, 1'b0, -1);
    wait_drain();

    // Mode 1, CS released after 5 bits 1,0,1,1,0
    mb = 64'b01101;
    sb = 64'b10010;
    run_frame(1'b0, 1'b1, 1'b1, 5, mb, sb, 99, 1'b0, -1);
    wait_drain();

    // Mode 2, LSB-first 0x81 with cfg toggled mid-frame
    mb = words_to_bits(64'h81, 1, 1'b0);
    sb = words_to_bits(64'h5A, 1, 1'b0);
    run_frame(1'b1, 1'b0, 1'b0, 8, mb, sb, 99, 1'b1, -1);
    wait_drain();

    // Overflow: five words with the consumer stalled
    hold_ready = 1'b1;
    mb = words_to_bits(64'h5544332211, 5, 1'b1);
    sb = words_to_bits(64'hAABBCCDDEE, 5, 1'b1);
    run_frame(1'b0, 1'b0, 1'b1, 40, mb, sb, FIFO_DEPTH, 1'b0, -1);
    check1("overflow_set", {31'd0, overflow}, 32'd1);
    check1("valid_while_stalled", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    clear_ovf = 1'b1;
    @(negedge clk);
    clear_ovf = 1'b0;
    @(negedge clk);
    check1("overflow_cleared", {31'd0, overflow}, 32'd0);
    hold_ready = 1'b0;
    wait_drain();

    // Reset mid-frame after 3 bits: frame discarded, next frame normal
    mb = words_to_bits(64'hF0, 1, 1'b1);
    sb = words_to_bits(64'h0F, 1, 1'b1);
    run_frame(1'b0, 1'b0, 1'b1, 8, mb, sb, 99, 1'b0, 3);
    wait_drain();
    mb = words_to_bits(64'h6C, 1, 1'b1);
    sb = words_to_bits(64'h93, 1, 1'b1);
    run_frame(1'b0, 1'b0, 1'b1, 8, mb, sb, 99, 1'b0, -1);
    wait_drain();

    // Randomised frames across modes, orders and lengths
    for (int f = 0; f < 30; f++) begin
      mb = {$urandom, $urandom};
      sb = {$urandom, $urandom};
      run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(1, 24), mb, sb, 99, 1'b0, -1);
    end
    wait_drain();
    check1("no_overflow_after_random", {31'd0, overflow}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete, %0d checks so far", checks);
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
